// File: rtl/dmem_copy_engine.sv
// rtl/dmem_copy_engine.sv - memmove-style word copy engine driving the data-memory port
module dmem_copy_engine #(
  parameter int LEN_W = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_write_en,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [31:0]      hold;
  logic [LEN_W-1:0] count;
  logic             err_q;
  logic             desc;

  logic [31:0] span;
  logic [31:0] last_off;
  logic [32:0] src_end;
  logic        misaligned;
  logic        overlap_down;

  // A destination that starts inside the source block must be filled from the top down.
  assign span         = 32'(len) << 2;
  assign last_off     = span - 32'd4;
  assign src_end      = {1'b0, src_addr} + {1'b0, span};
  assign overlap_down = (dst_addr > src_addr) && ({1'b0, dst_addr} < src_end);
  assign misaligned   = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      hold    <= '0;
      count   <= '0;
      err_q   <= 1'b0;
      desc    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            err_q <= misaligned;
            desc  <= overlap_down;
            count <= len;
            if (overlap_down) begin
              src_ptr <= src_addr + last_off;
              dst_ptr <= dst_addr + last_off;
            end else begin
              src_ptr <= src_addr;
              dst_ptr <= dst_addr;
            end
            state <= (misaligned || (len == '0)) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          hold  <= mem_read_data;
          state <= S_WRITE;
        end
        S_WRITE: begin
          src_ptr <= desc ? src_ptr - 32'd4 : src_ptr + 32'd4;
          dst_ptr <= desc ? dst_ptr - 32'd4 : dst_ptr + 32'd4;
          count   <= count - LEN_W'(1);
          state   <= (count > LEN_W'(1)) ? S_READ : S_DONE;
        end
        S_DONE: begin
          err_q <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign err          = (state == S_DONE) && err_q;
  assign mem_write_en = (state == S_WRITE);

  always_comb begin
    mem_addr       = '0;
    mem_write_data = '0;
    case (state)
      S_READ:  mem_addr = src_ptr;
      S_WRITE: begin
        mem_addr       = dst_ptr;
        mem_write_data = hold;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// tb/tb_dmem_copy_engine.sv - self-checking bench for dmem_copy_engine with memmove reference model
module tb_dmem_copy_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [6:0]  len = '0;
  logic        busy, done, err, mem_write_en;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem   [0:255];
  logic [31:0] img   [0:255];
  logic [31:0] model [0:255];
  logic        ld = 1'b0;

  always #5 clk = ~clk;

  dmem_copy_engine #(.LEN_W(7)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  assign mem_read_data = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (mem_write_en) begin
      mem[mem_addr[9:2]] <= mem_write_data;
    end
  end

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [6:0]  len;
    logic        exp_err;
    int          exp_cyc;
    logic [31:0] exp_first;
  } vec_t;

  vec_t vecs [0:9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_image(input bit random_fill);
    for (int i = 0; i < 256; i++) begin
      img[i]   = random_fill ? $urandom : 32'(i + 1);
      model[i] = img[i];
    end
    @(negedge clk); ld = 1'b1;
    @(negedge clk); ld = 1'b0;
  endtask

  // Reference: memmove through a temporary buffer, word-indexed memory.
  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int l);
    logic [31:0] tmp [0:127];
    if (s[1:0] != 2'b00 || d[1:0] != 2'b00 || l == 0) return;
    for (int k = 0; k < l; k++) tmp[k] = model[(int'(s >> 2) + k) & 255];
    for (int k = 0; k < l; k++) model[(int'(d >> 2) + k) & 255] = tmp[k];
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== model[i]) bad++;
    check(name, 64'(bad), 64'd0);
  endtask

  task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input logic [6:0] l,
                         input int pulse_at, output int cyc, output int dones,
                         output logic err_seen, output int wrs, output logic [31:0] first_wr);
    cyc = 0; dones = 0; err_seen = 1'b0; wrs = 0; first_wr = '0;
    @(negedge clk);
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom; len = 7'($urandom);
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      cyc++;
      if (done) begin dones++; err_seen = err_seen | err; end
      if (mem_write_en) begin
        if (wrs == 0) first_wr = mem_addr;
        wrs++;
      end
      @(negedge clk);
      start = (i + 1 == pulse_at);
    end
    start = 1'b0;
    if (busy) check("busy_timeout", 64'(busy), 64'd0);
  endtask

  int          cyc, dones, wrs, exp_cyc;
  logic        err_seen, exp_err;
  logic [31:0] first_wr, rs, rd;
  logic [6:0]  rl;

  initial begin
    vecs[0] = '{32'h00,  32'h40,  7'd3,  1'b0, 7,   32'h40};
    vecs[1] = '{32'h00,  32'h04,  7'd4,  1'b0, 9,   32'h10};
    vecs[2] = '{32'h04,  32'h00,  7'd3,  1'b0, 7,   32'h00};
    vecs[3] = '{32'h80,  32'h90,  7'd0,  1'b0, 1,   32'h00};
    vecs[4] = '{32'h02,  32'h40,  7'd5,  1'b1, 1,   32'h00};
    vecs[5] = '{32'h00,  32'h41,  7'd2,  1'b1, 1,   32'h00};
    vecs[6] = '{32'h20,  32'h20,  7'd4,  1'b0, 9,   32'h20};
    vecs[7] = '{32'h30,  32'h34,  7'd1,  1'b0, 3,   32'h34};
    vecs[8] = '{32'h30,  32'h3C,  7'd4,  1'b0, 9,   32'h48};
    vecs[9] = '{32'h000, 32'h100, 7'd64, 1'b0, 129, 32'h100};

    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_we", 64'(mem_write_en), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_write_data), 64'd0);
    @(negedge clk); reset_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      load_image(1'b0);
      model_copy(vecs[v].src, vecs[v].dst, int'(vecs[v].len));
      do_copy(vecs[v].src, vecs[v].dst, vecs[v].len, -1, cyc, dones, err_seen, wrs, first_wr);
      check($sformatf("v%0d_busy_cycles", v), 64'(cyc), 64'(vecs[v].exp_cyc));
      check($sformatf("v%0d_done_count", v), 64'(dones), 64'd1);
      check($sformatf("v%0d_err", v), 64'(err_seen), 64'(vecs[v].exp_err));
      check($sformatf("v%0d_writes", v), 64'(wrs),
            64'((vecs[v].exp_err || vecs[v].len == 0) ? 0 : int'(vecs[v].len)));
      check($sformatf("v%0d_first_wr", v), 64'(first_wr), 64'(vecs[v].exp_first));
      check_mem($sformatf("v%0d_mem_words_wrong", v));
    end

    for (int t = 0; t < 20; t++) begin
      rs = 32'($urandom_range(0, 127)) << 2;
      rd = 32'($urandom_range(0, 127)) << 2;
      if ($urandom_range(0, 7) == 0) rs[1:0] = 2'($urandom_range(1, 3));
      rl = 7'($urandom_range(0, 64));
      exp_err = (rs[1:0] != 2'b00);
      exp_cyc = (exp_err || rl == 0) ? 1 : 2 * int'(rl) + 1;
      load_image(1'b1);
      model_copy(rs, rd, int'(rl));
      do_copy(rs, rd, rl, -1, cyc, dones, err_seen, wrs, first_wr);
      check($sformatf("r%0d_busy_cycles", t), 64'(cyc), 64'(exp_cyc));
      check($sformatf("r%0d_done_count", t), 64'(dones), 64'd1);
      check($sformatf("r%0d_err", t), 64'(err_seen), 64'(exp_err));
      check_mem($sformatf("r%0d_mem_words_wrong", t));
    end

    // start pulsed mid-copy must be ignored
    load_image(1'b1);
    model_copy(32'h100, 32'h200, 8);
    do_copy(32'h100, 32'h200, 7'd8, 4, cyc, dones, err_seen, wrs, first_wr);
    check("busy_start_cycles", 64'(cyc), 64'd17);
    check("busy_start_dones", 64'(dones), 64'd1);
    check_mem("busy_start_mem_words_wrong");
    @(negedge clk);
    check("busy_start_no_relaunch", 64'(busy), 64'd0);

    // asynchronous reset during a WRITE cycle
    @(negedge clk);
    src_addr = 32'h0; dst_addr = 32'h80; len = 7'd8; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20 && !mem_write_en; i++) @(negedge clk);
    check("rst_mid_reached_write", 64'(mem_write_en), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_we_drop", 64'(mem_write_en), 64'd0);
    check("rst_mid_busy_drop", 64'(busy), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    check("rst_mid_no_done", 64'(dones), 64'd0);

    load_image(1'b1);
    model_copy(32'h0, 32'h80, 8);
    do_copy(32'h0, 32'h80, 7'd8, -1, cyc, dones, err_seen, wrs, first_wr);
    check("post_rst_cycles", 64'(cyc), 64'd17);
    check("post_rst_dones", 64'(dones), 64'd1);
    check_mem("post_rst_mem_words_wrong");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
